// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multicycle controller: FSM states, opcode
// values, opcode classes and the datapath mux encodings.
package multicycle_ctrl_pkg;

  // Controller states; the encoding is visible on state_dbg.
  typedef enum logic [2:0] {
    ST_FETCH   = 3'd0,
    ST_DECODE  = 3'd1,
    ST_EXEC    = 3'd2,
    ST_MEM     = 3'd3,
    ST_WB      = 3'd4,
    ST_HALT    = 3'd5,
    ST_ILLEGAL = 3'd6,
    ST_BUSERR  = 3'd7
  } state_e;

  // Supported opcodes (instruction bits [6:0]).
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  // Instruction classes produced by the opcode decoder.
  typedef enum logic [2:0] {
    CLS_ALU_R  = 3'd0,
    CLS_ALU_I  = 3'd1,
    CLS_LOAD   = 3'd2,
    CLS_STORE  = 3'd3,
    CLS_BRANCH = 3'd4,
    CLS_LUI    = 3'd5,
    CLS_BAD    = 3'd6
  } op_class_e;

  // Next-PC select.
  localparam logic MUXA_PLUS4  = 1'b0;
  localparam logic MUXA_BRANCH = 1'b1;

  // ALU B operand select.
  localparam logic [1:0] MUXB_IMM_EX = 2'b00;
  localparam logic [1:0] MUXB_IMM_SW = 2'b01;
  localparam logic [1:0] MUXB_DOB    = 2'b10;

  // Write-back select.
  localparam logic [1:0] MUXC_ALU  = 2'b00;
  localparam logic [1:0] MUXC_MEM  = 2'b01;
  localparam logic [1:0] MUXC_UIMM = 2'b10;

  // ALU operation.
  localparam logic ALU_ADD = 1'b0;
  localparam logic ALU_SUB = 1'b1;

endpackage

// File: rtl/multicycle_ctrl_opcode_class.sv
// Combinational opcode-to-class decoder for the multicycle controller.
module opcode_class
  import multicycle_ctrl_pkg::*;
(
  input  logic [6:0] opcode_i,
  output op_class_e  op_class_o
);

  // Map each supported opcode to its class; anything else is illegal.
  always_comb begin
    op_class_o = CLS_BAD;
    case (opcode_i)
      OP_RTYPE:  op_class_o = CLS_ALU_R;
      OP_ITYPE:  op_class_o = CLS_ALU_I;
      OP_LOAD:   op_class_o = CLS_LOAD;
      OP_STORE:  op_class_o = CLS_STORE;
      OP_BRANCH: op_class_o = CLS_BRANCH;
      OP_LUI:    op_class_o = CLS_LUI;
      default:   op_class_o = CLS_BAD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle instruction controller: FETCH/DECODE/EXEC/MEM/WB sequencing
// with memory wait timeout, halt handling, sticky error states and a
// retired-instruction counter. All control outputs are combinational.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  opcode,
  input  logic        funct7_5,
  input  logic        cero,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  input  logic        halt_req,
  output logic        imem_req,
  output logic        dmem_req,
  output logic        ir_we,
  output logic        pc_we,
  output logic        MEM_RD,
  output logic        MEM_WR,
  output logic        REG_WR,
  output logic        S_Mux_A,
  output logic [1:0]  S_Mux_B,
  output logic [1:0]  S_Mux_C,
  output logic        control_ALU,
  output logic [31:0] retired,
  output logic        illegal,
  output logic        bus_err,
  output logic        halted,
  output logic [2:0]  state_dbg
);

  localparam int unsigned WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [31:0]       retired_q, retired_d;
  logic              illegal_q, illegal_d;
  logic              bus_err_q, bus_err_d;
  logic              retire;
  op_class_e         op_class;
  logic [1:0]        cls_mux_b;
  logic              cls_alu;

  opcode_class u_opcode_class (
    .opcode_i   (opcode),
    .op_class_o (op_class)
  );

  // Operand selects implied by the instruction class, shared by EXEC and MEM.
  always_comb begin
    cls_mux_b = MUXB_IMM_EX;
    cls_alu   = ALU_ADD;
    case (op_class)
      CLS_ALU_R: begin
        cls_mux_b = MUXB_DOB;
        cls_alu   = funct7_5;
      end
      CLS_STORE:  cls_mux_b = MUXB_IMM_SW;
      CLS_BRANCH: begin
        cls_mux_b = MUXB_DOB;
        cls_alu   = ALU_SUB;
      end
      default: begin
        cls_mux_b = MUXB_IMM_EX;
        cls_alu   = ALU_ADD;
      end
    endcase
  end

  // Next-state and output decode; everything stays idle while in reset.
  always_comb begin
    state_d     = state_q;
    retire      = 1'b0;
    imem_req    = 1'b0;
    dmem_req    = 1'b0;
    ir_we       = 1'b0;
    pc_we       = 1'b0;
    MEM_RD      = 1'b0;
    MEM_WR      = 1'b0;
    REG_WR      = 1'b0;
    S_Mux_A     = MUXA_PLUS4;
    S_Mux_B     = MUXB_IMM_EX;
    S_Mux_C     = MUXC_ALU;
    control_ALU = ALU_ADD;
    if (rst_n) begin
      case (state_q)
        ST_FETCH: begin
          imem_req = 1'b1;
          if (imem_ready) begin
            ir_we   = 1'b1;
            state_d = ST_DECODE;
          end else if (wait_q == WAIT_LIMIT) begin
            state_d = ST_BUSERR;
          end
        end
        ST_DECODE: state_d = (op_class == CLS_BAD) ? ST_ILLEGAL : ST_EXEC;
        ST_EXEC: begin
          S_Mux_B     = cls_mux_b;
          control_ALU = cls_alu;
          case (op_class)
            CLS_ALU_R, CLS_ALU_I, CLS_LUI: state_d = ST_WB;
            CLS_LOAD, CLS_STORE:           state_d = ST_MEM;
            CLS_BRANCH: begin
              pc_we   = 1'b1;
              S_Mux_A = ~cero;
              retire  = 1'b1;
            end
            default: state_d = ST_ILLEGAL;
          endcase
        end
        ST_MEM: begin
          S_Mux_B     = cls_mux_b;
          control_ALU = cls_alu;
          // Only LOAD/STORE can reach MEM; a changed opcode is treated as illegal.
          if (op_class == CLS_LOAD || op_class == CLS_STORE) begin
            dmem_req = 1'b1;
            MEM_RD   = (op_class == CLS_LOAD);
            MEM_WR   = (op_class == CLS_STORE);
            if (dmem_ready) begin
              if (op_class == CLS_LOAD) begin
                state_d = ST_WB;
              end else begin
                pc_we  = 1'b1;
                retire = 1'b1;
              end
            end else if (wait_q == WAIT_LIMIT) begin
              state_d = ST_BUSERR;
            end
          end else begin
            state_d = ST_ILLEGAL;
          end
        end
        ST_WB: begin
          REG_WR = 1'b1;
          pc_we  = 1'b1;
          retire = 1'b1;
          case (op_class)
            CLS_LOAD: S_Mux_C = MUXC_MEM;
            CLS_LUI:  S_Mux_C = MUXC_UIMM;
            default:  S_Mux_C = MUXC_ALU;
          endcase
        end
        ST_HALT: begin
          if (!halt_req) state_d = ST_FETCH;
        end
        default: state_d = state_q;  // ILLEGAL and BUSERR hold until reset
      endcase
      // Any retiring cycle goes back to FETCH unless a halt is pending.
      if (retire) state_d = halt_req ? ST_HALT : ST_FETCH;
    end
  end

  // Wait counter, retire counter and sticky error flags next values.
  always_comb begin
    wait_d = wait_q;
    if (state_d != state_q) begin
      wait_d = '0;
    end else if ((state_q == ST_FETCH && !imem_ready) ||
                 (state_q == ST_MEM && !dmem_ready)) begin
      wait_d = wait_q + WAIT_W'(1);
    end
    retired_d = retired_q + {31'd0, retire};
    illegal_d = illegal_q | (state_d == ST_ILLEGAL);
    bus_err_d = bus_err_q | (state_d == ST_BUSERR);
  end

  // State and counter registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_FETCH;
      wait_q    <= '0;
      retired_q <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      retired_q <= retired_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign retired   = retired_q;
  assign illegal   = illegal_q;
  assign bus_err   = bus_err_q;
  assign halted    = (state_q == ST_HALT);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed, table-driven bench for multicycle_ctrl plus hand-written
// sequences for the timeout, sticky-error and reset-abort corner cases.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, funct7_5, cero, imem_ready, dmem_ready, halt_req;
  logic [6:0]  opcode;
  logic        imem_req, dmem_req, ir_we, pc_we, MEM_RD, MEM_WR, REG_WR;
  logic        S_Mux_A, control_ALU, illegal, bus_err, halted;
  logic [1:0]  S_Mux_B, S_Mux_C;
  logic [31:0] retired;
  logic [2:0]  state_dbg;

  always #5 clk = ~clk;

  multicycle_ctrl #(.MAX_WAIT(15)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct7_5(funct7_5), .cero(cero),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready), .halt_req(halt_req),
    .imem_req(imem_req), .dmem_req(dmem_req), .ir_we(ir_we), .pc_we(pc_we),
    .MEM_RD(MEM_RD), .MEM_WR(MEM_WR), .REG_WR(REG_WR), .S_Mux_A(S_Mux_A),
    .S_Mux_B(S_Mux_B), .S_Mux_C(S_Mux_C), .control_ALU(control_ALU),
    .retired(retired), .illegal(illegal), .bus_err(bus_err), .halted(halted),
    .state_dbg(state_dbg)
  );

  localparam logic [6:0] R = 7'b0110011, I = 7'b0010011, LD = 7'b0000011;
  localparam logic [6:0] ST = 7'b0100011, BR = 7'b1100011, LU = 7'b0110111;
  localparam logic [6:0] BAD = 7'b1111111;
  localparam logic [2:0] F = 3'd0, D = 3'd1, E = 3'd2, M = 3'd3, W = 3'd4;
  localparam logic [2:0] H = 3'd5, IL = 3'd6, BE = 3'd7;
  // Strobe order: {imem_req, dmem_req, ir_we, pc_we, MEM_RD, MEM_WR, REG_WR}
  localparam logic [6:0] S0 = 7'b0000000, SF = 7'b1010000, SI = 7'b1000000;
  localparam logic [6:0] SW = 7'b0001001, SL = 7'b0100100, SS = 7'b0100010;
  localparam logic [6:0] SR = 7'b0101010, SP = 7'b0001000;

  wire [6:0] strb_act = {imem_req, dmem_req, ir_we, pc_we, MEM_RD, MEM_WR, REG_WR};
  wire [2:0] flg_act  = {illegal, bus_err, halted};

  typedef struct {
    string       name;
    logic        rst_n;
    logic [6:0]  op;
    logic        f7, cz, ir, dr, hr;
    logic [2:0]  st;
    logic [6:0]  strb;
    logic        sa;
    logic [1:0]  sb, sc;
    logic        alu;
    logic [2:0]  flg;
    logic [31:0] ret;
  } vec_t;

  vec_t vecs[$];
  int   tests = 0;
  int   fails = 0;
  int   n;

  function automatic vec_t mk(string nm, logic r, logic [6:0] op, logic f7, logic cz,
                              logic ir, logic dr, logic hr, logic [2:0] st,
                              logic [6:0] strb, logic sa, logic [1:0] sb, logic [1:0] sc,
                              logic alu, logic [2:0] flg, logic [31:0] ret);
    vec_t v;
    v.name = nm; v.rst_n = r; v.op = op; v.f7 = f7; v.cz = cz; v.ir = ir; v.dr = dr;
    v.hr = hr; v.st = st; v.strb = strb; v.sa = sa; v.sb = sb; v.sc = sc; v.alu = alu;
    v.flg = flg; v.ret = ret;
    return v;
  endfunction

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input int idx, input vec_t v);
    rst_n = v.rst_n; opcode = v.op; funct7_5 = v.f7; cero = v.cz;
    imem_ready = v.ir; dmem_ready = v.dr; halt_req = v.hr;
    #1;
    $display("[TB] vec %0d %s state=%0d strb=%b retired=%0d", idx, v.name, state_dbg,
             strb_act, retired);
    check(v.name,
          {13'd0, state_dbg, strb_act, S_Mux_A, S_Mux_B, S_Mux_C, control_ALU, flg_act, retired},
          {13'd0, v.st, v.strb, v.sa, v.sb, v.sc, v.alu, v.flg, v.ret});
    tick();
  endtask

  initial begin
    // name, rst, op, f7, cero, ir, dr, hr | st, strobes, A, B, C, alu, flags, retired
    vecs.push_back(mk("reset_idle",  0, R, 0, 0, 1, 1, 0, F, S0, 0, 2'd0, 2'd0, 0, 3'b000, 0));
    vecs.push_back(mk("add_fetch",   1, R, 0, 0, 1, 0, 0, F, SF, 0, 2'd0, 2'd0, 0, 3'b000, 0));
    vecs.push_back(mk("add_decode",  1, R, 0, 0, 1, 0, 0, D, S0, 0, 2'd0, 2'd0, 0, 3'b000, 0));
    vecs.push_back(mk("add_exec",    1, R, 0, 0, 1, 0, 0, E, S0, 0, 2'd2, 2'd0, 0, 3'b000, 0));
    vecs.push_back(mk("add_wb",      1, R, 0, 0, 1, 0, 0, W, SW, 0, 2'd0, 2'd0, 0, 3'b000, 0));
    vecs.push_back(mk("sub_fetch",   1, R, 1, 0, 1, 0, 0, F, SF, 0, 2'd0, 2'd0, 0, 3'b000, 1));
    vecs.push_back(mk("sub_decode",  1, R, 1, 0, 1, 0, 0, D, S0, 0, 2'd0, 2'd0, 0, 3'b000, 1));
    vecs.push_back(mk("sub_exec",    1, R, 1, 0, 1, 0, 0, E, S0, 0, 2'd2, 2'd0, 1, 3'b000, 1));
    vecs.push_back(mk("sub_wb",      1, R, 1, 0, 1, 0, 0, W, SW, 0, 2'd0, 2'd0, 0, 3'b000, 1));
    vecs.push_back(mk("addi_wait1",  1, I, 0, 0, 0, 0, 0, F, SI, 0, 2'd0, 2'd0, 0, 3'b000, 2));
    vecs.push_back(mk("addi_wait2",  1, I, 0, 0, 0, 0, 0, F, SI, 0, 2'd0, 2'd0, 0, 3'b000, 2));
    vecs.push_back(mk("addi_fetch",  1, I, 0, 0, 1, 0, 0, F, SF, 0, 2'd0, 2'd0, 0, 3'b000, 2));
    vecs.push_back(mk("addi_decode", 1, I, 0, 0, 1, 0, 0, D, S0, 0, 2'd0, 2'd0, 0, 3'b000, 2));
    vecs.push_back(mk("addi_exec",   1, I, 0, 0, 1, 0, 0, E, S0, 0, 2'd0, 2'd0, 0, 3'b000, 2));
    vecs.push_back(mk("addi_wb",     1, I, 0, 0, 1, 0, 0, W, SW, 0, 2'd0, 2'd0, 0, 3'b000, 2));
    vecs.push_back(mk("lw_fetch",    1, LD, 0, 0, 1, 0, 0, F, SF, 0, 2'd0, 2'd0, 0, 3'b000, 3));
    vecs.push_back(mk("lw_decode",   1, LD, 0, 0, 1, 0, 0, D, S0, 0, 2'd0, 2'd0, 0, 3'b000, 3));
    vecs.push_back(mk("lw_exec",     1, LD, 0, 0, 1, 0, 0, E, S0, 0, 2'd0, 2'd0, 0, 3'b000, 3));
    vecs.push_back(mk("lw_mem1",     1, LD, 0, 0, 1, 0, 0, M, SL, 0, 2'd0, 2'd0, 0, 3'b000, 3));
    vecs.push_back(mk("lw_mem2",     1, LD, 0, 0, 1, 0, 0, M, SL, 0, 2'd0, 2'd0, 0, 3'b000, 3));
    vecs.push_back(mk("lw_mem3",     1, LD, 0, 0, 1, 0, 0, M, SL, 0, 2'd0, 2'd0, 0, 3'b000, 3));
    vecs.push_back(mk("lw_mem4",     1, LD, 0, 0, 1, 0, 0, M, SL, 0, 2'd0, 2'd0, 0, 3'b000, 3));
    vecs.push_back(mk("lw_mem5_rdy", 1, LD, 0, 0, 1, 1, 0, M, SL, 0, 2'd0, 2'd0, 0, 3'b000, 3));
    vecs.push_back(mk("lw_wb",       1, LD, 0, 0, 1, 0, 0, W, SW, 0, 2'd0, 2'd1, 0, 3'b000, 3));
    vecs.push_back(mk("bne_t_fetch", 1, BR, 0, 0, 1, 0, 0, F, SF, 0, 2'd0, 2'd0, 0, 3'b000, 4));
    vecs.push_back(mk("bne_t_dec",   1, BR, 0, 0, 1, 0, 0, D, S0, 0, 2'd0, 2'd0, 0, 3'b000, 4));
    vecs.push_back(mk("bne_t_exec",  1, BR, 0, 0, 1, 0, 0, E, SP, 1, 2'd2, 2'd0, 1, 3'b000, 4));
    vecs.push_back(mk("bne_n_fetch", 1, BR, 0, 1, 1, 0, 0, F, SF, 0, 2'd0, 2'd0, 0, 3'b000, 5));
    vecs.push_back(mk("bne_n_dec",   1, BR, 0, 1, 1, 0, 0, D, S0, 0, 2'd0, 2'd0, 0, 3'b000, 5));
    vecs.push_back(mk("bne_n_exec",  1, BR, 0, 1, 1, 0, 0, E, SP, 0, 2'd2, 2'd0, 1, 3'b000, 5));
    vecs.push_back(mk("lui_fetch",   1, LU, 0, 0, 1, 0, 0, F, SF, 0, 2'd0, 2'd0, 0, 3'b000, 6));
    vecs.push_back(mk("lui_decode",  1, LU, 0, 0, 1, 0, 0, D, S0, 0, 2'd0, 2'd0, 0, 3'b000, 6));
    vecs.push_back(mk("lui_exec",    1, LU, 0, 0, 1, 0, 0, E, S0, 0, 2'd0, 2'd0, 0, 3'b000, 6));
    vecs.push_back(mk("lui_wb",      1, LU, 0, 0, 1, 0, 0, W, SW, 0, 2'd0, 2'd2, 0, 3'b000, 6));
    vecs.push_back(mk("sw_fetch",    1, ST, 0, 0, 1, 0, 0, F, SF, 0, 2'd0, 2'd0, 0, 3'b000, 7));
    vecs.push_back(mk("sw_decode",   1, ST, 0, 0, 1, 0, 0, D, S0, 0, 2'd0, 2'd0, 0, 3'b000, 7));
    vecs.push_back(mk("sw_exec",     1, ST, 0, 0, 1, 0, 0, E, S0, 0, 2'd1, 2'd0, 0, 3'b000, 7));
    vecs.push_back(mk("sw_mem_wait", 1, ST, 0, 0, 1, 0, 0, M, SS, 0, 2'd1, 2'd0, 0, 3'b000, 7));
    vecs.push_back(mk("sw_ret_halt", 1, ST, 0, 0, 1, 1, 1, M, SR, 0, 2'd1, 2'd0, 0, 3'b000, 7));
    vecs.push_back(mk("halt_hold",   1, R, 0, 0, 1, 1, 1, H, S0, 0, 2'd0, 2'd0, 0, 3'b001, 8));
    vecs.push_back(mk("halt_drop",   1, R, 0, 0, 1, 1, 0, H, S0, 0, 2'd0, 2'd0, 0, 3'b001, 8));
    vecs.push_back(mk("resume",      1, R, 0, 0, 0, 0, 0, F, SI, 0, 2'd0, 2'd0, 0, 3'b000, 8));
    vecs.push_back(mk("bad_fetch",   1, BAD, 0, 0, 1, 0, 0, F, SF, 0, 2'd0, 2'd0, 0, 3'b000, 8));
    vecs.push_back(mk("bad_decode",  1, BAD, 0, 0, 1, 0, 0, D, S0, 0, 2'd0, 2'd0, 0, 3'b000, 8));
    vecs.push_back(mk("illegal1",    1, BAD, 0, 0, 1, 1, 0, IL, S0, 0, 2'd0, 2'd0, 0, 3'b100, 8));
    vecs.push_back(mk("illegal2",    1, R, 0, 0, 1, 1, 0, IL, S0, 0, 2'd0, 2'd0, 0, 3'b100, 8));

    rst_n = 1'b0; opcode = R; funct7_5 = 1'b0; cero = 1'b0;
    imem_ready = 1'b0; dmem_ready = 1'b0; halt_req = 1'b0;
    tick();
    tick();

    for (int i = 0; i < vecs.size(); i++) apply(i, vecs[i]);

    // Ready arriving in the cycle the wait limit is reached wins.
    rst_n = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0; opcode = R;
    tick();
    rst_n = 1'b1;
    #1;
    $display("[TB] seq reset_after_illegal state=%0d flags=%b", state_dbg, flg_act);
    check("reset_clears_illegal", {state_dbg, flg_act}, {F, 3'b000});
    repeat (15) tick();
    imem_ready = 1'b1;
    #1;
    check("fetch_at_wait_limit", strb_act, SF);
    tick();
    $display("[TB] seq ready_at_limit state=%0d", state_dbg);
    check("ready_wins_timeout", state_dbg, D);

    // Instruction memory never ready: bus error after the tolerated wait.
    imem_ready = 1'b0;
    repeat (3) tick();
    n = 0;
    while (state_dbg != BE && n < 40) begin
      tick();
      n++;
    end
    $display("[TB] seq buserr after %0d fetch cycles", n);
    check("buserr_wait_cycles", n, 16);
    imem_ready = 1'b1; dmem_ready = 1'b1;
    #1;
    check("buserr_flag_strobes", {flg_act, strb_act}, {3'b010, S0});
    repeat (3) tick();
    check("buserr_sticky", {state_dbg, flg_act}, {BE, 3'b010});
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; imem_ready = 1'b0; dmem_ready = 1'b0;
    #1;
    $display("[TB] seq buserr_reset state=%0d flags=%b", state_dbg, flg_act);
    check("buserr_cleared", {state_dbg, flg_act, retired}, {F, 3'b000, 32'd0});

    // Reset in WB aborts the instruction.
    opcode = R; imem_ready = 1'b1;
    repeat (4) tick();
    check("retired_before_abort", retired, 1);
    repeat (3) tick();
    check("reached_wb", state_dbg, W);
    rst_n = 1'b0;
    #1;
    $display("[TB] seq reset_in_wb strb=%b", strb_act);
    check("no_strobes_reset_wb", {strb_act, S_Mux_A, S_Mux_B, S_Mux_C, control_ALU}, 13'd0);
    tick();
    rst_n = 1'b1; imem_ready = 1'b0;
    #1;
    $display("[TB] seq after_abort state=%0d retired=%0d", state_dbg, retired);
    check("post_abort_state", {state_dbg, retired}, {F, 32'd0});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
